// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with hardwired r0 and hardware clear sweep
// Optional macro REGFILE_BYPASS_EN: same-cycle forwarding of accepted writes to read ports.
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int R_WIDTH = 5,
  parameter int REGSIZE = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NRD*R_WIDTH-1:0] read_reg_d,
  output logic [NRD*WIDTH-1:0]   read_data_q,
  input  logic [NWR-1:0]         regwrite_d,
  input  logic [NWR*R_WIDTH-1:0] write_reg_d,
  input  logic [NWR*WIDTH-1:0]   write_data_d,
  input  logic                   init_req_i,
  output logic                   ready_q
);

  localparam int AW = (REGSIZE > 1) ? $clog2(REGSIZE) : 1;
  localparam int CW = $clog2(REGSIZE) + 1;
  localparam logic [R_WIDTH:0] REG_LIMIT = (R_WIDTH + 1)'(REGSIZE);
  localparam logic [CW-1:0]    LAST_IDX  = CW'(REGSIZE - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs [REGSIZE];
  logic [NWR-1:0]   wr_ok;

  function automatic logic valid_addr(input logic [R_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < REG_LIMIT);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops at REGSIZE once the sweep is done; it is reloaded on entry to CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_READY;
      end
      S_READY: begin
        if (init_req_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign ready_q = (state_q == S_READY);

  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = rst_n_i && (state_q == S_READY) && !init_req_i && regwrite_d[w]
                 && valid_addr(write_reg_d[w*R_WIDTH +: R_WIDTH]);
    end
  end

  // Later ports are applied last, so the highest-index port wins on a shared address.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && (state_q == S_CLEAR)) begin
      regs[cnt_q[AW-1:0]] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) regs[write_reg_d[w*R_WIDTH +: AW]] <= write_data_d[w*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    read_data_q = '0;
    for (int k = 0; k < NRD; k++) begin
      if ((state_q == S_READY) && valid_addr(read_reg_d[k*R_WIDTH +: R_WIDTH])) begin
        read_data_q[k*WIDTH +: WIDTH] = regs[read_reg_d[k*R_WIDTH +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wr_ok[w] && (write_reg_d[w*R_WIDTH +: R_WIDTH] == read_reg_d[k*R_WIDTH +: R_WIDTH]))
            read_data_q[k*WIDTH +: WIDTH] = write_data_d[w*WIDTH +: WIDTH];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int WIDTH   = 32;
  localparam int R_WIDTH = 5;
  localparam int REGSIZE = 32;
  localparam int NRD     = 2;
  localparam int NWR     = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NRD*R_WIDTH-1:0] read_reg;
  logic [NRD*WIDTH-1:0]   read_data;
  logic [NWR-1:0]         regwrite;
  logic [NWR*R_WIDTH-1:0] write_reg;
  logic [NWR*WIDTH-1:0]   write_data;
  logic                   init_req;
  logic                   ready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] mem [REGSIZE];
  bit               m_ready = 1'b0;
  int               m_left  = REGSIZE;

  regfile_mp #(.WIDTH(WIDTH), .R_WIDTH(R_WIDTH), .REGSIZE(REGSIZE), .NRD(NRD), .NWR(NWR)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .read_reg_d(read_reg), .read_data_q(read_data),
    .regwrite_d(regwrite), .write_reg_d(write_reg), .write_data_d(write_data),
    .init_req_i(init_req), .ready_q(ready)
  );

  always #5 clk = ~clk;

  // Model step for the coming edge from the inputs now presented, then advance past the edge.
  task automatic tick();
    int a;
    if (!rst_n) begin
      m_ready = 1'b0;
      m_left  = REGSIZE;
    end else if (!m_ready) begin
      mem[REGSIZE - m_left] = '0;
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else if (init_req) begin
      m_ready = 1'b0;
      m_left  = REGSIZE;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        a = int'(write_reg[w*R_WIDTH +: R_WIDTH]);
        if (regwrite[w] && a != 0 && a < REGSIZE) mem[a] = write_data[w*WIDTH +: WIDTH];
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] exp_read(input int a);
    logic [WIDTH-1:0] v;
    if (!m_ready || a == 0 || a >= REGSIZE) return '0;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (rst_n && !init_req && regwrite[w] && int'(write_reg[w*R_WIDTH +: R_WIDTH]) == a)
        v = write_data[w*WIDTH +: WIDTH];
`endif
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; init_req = 1'b0; regwrite = '0; read_reg = '0; write_reg = '0; write_data = '0;
    repeat (3) tick();
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    rst_n = 1'b1;
    for (int i = 1; i <= REGSIZE; i++) begin
      read_reg   = NRD*R_WIDTH'($urandom);
      regwrite   = NWR'($urandom);
      write_reg  = NWR*R_WIDTH'($urandom);
      write_data = {$urandom, $urandom};
      #1;
      for (int k = 0; k < NRD; k++) begin
        n_cmp++;
        if (read_data[k*WIDTH +: WIDTH] !== '0) begin
          n_fail++;
          $display("FAIL sweep_read edge %0d port %0d: got %h want 0", i, k, read_data[k*WIDTH +: WIDTH]);
        end
      end
      tick();
      n_cmp++;
      if (ready !== (i == REGSIZE)) begin
        n_fail++;
        $display("FAIL sweep_ready edge %0d: got %b want %b", i, ready, (i == REGSIZE));
      end
    end
    regwrite = '0;
  endtask

  task automatic test_write_read();
    regwrite = 2'b01; write_reg = {5'd0, 5'd5}; write_data = {32'h0, 32'hDEADBEEF};
    tick();
    regwrite = '0; read_reg = {5'd5, 5'd0}; #1;
    n_cmp++;
    if (read_data[WIDTH +: WIDTH] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_r5: got %h want deadbeef", read_data[WIDTH +: WIDTH]);
    end
    regwrite = 2'b01; write_reg = {5'd0, 5'd0}; write_data = {32'h0, 32'h1234};
    tick();
    regwrite = '0; read_reg = {5'd0, 5'd0}; #1;
    n_cmp++;
    if (read_data[WIDTH-1:0] !== 32'h0) begin
      n_fail++; $display("FAIL wr_r0: got %h want 0", read_data[WIDTH-1:0]);
    end
  endtask

  task automatic test_same_addr();
    regwrite = 2'b11; write_reg = {5'd7, 5'd7}; write_data = {32'h22, 32'h11};
    tick();
    regwrite = '0; read_reg = {5'd7, 5'd7}; #1;
    n_cmp++;
    if (read_data[WIDTH-1:0] !== 32'h22) begin
      n_fail++; $display("FAIL same_addr_r7: got %h want 22", read_data[WIDTH-1:0]);
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] want_now;
`ifdef REGFILE_BYPASS_EN
    want_now = 32'hA5A5A5A5;
`else
    want_now = 32'h0;
`endif
    regwrite = 2'b01; write_reg = {5'd0, 5'd9}; write_data = {32'h0, 32'hA5A5A5A5};
    read_reg = {5'd0, 5'd9}; #1;
    n_cmp++;
    if (read_data[WIDTH-1:0] !== want_now) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", read_data[WIDTH-1:0], want_now);
    end
    n_cmp++;
    if (read_data[WIDTH +: WIDTH] !== 32'h0) begin
      n_fail++; $display("FAIL bypass_r0: got %h want 0", read_data[WIDTH +: WIDTH]);
    end
    tick();
    regwrite = '0; #1;
    n_cmp++;
    if (read_data[WIDTH-1:0] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h want a5a5a5a5", read_data[WIDTH-1:0]);
    end
  endtask

  task automatic test_init_req();
    int edges;
    regwrite = 2'b01; write_reg = {5'd0, 5'd3}; write_data = {32'h0, 32'h55};
    tick();
    init_req = 1'b1; regwrite = 2'b10; write_reg = {5'd4, 5'd0}; write_data = {32'h66, 32'h0};
    read_reg = {5'd3, 5'd4}; #1;
    n_cmp++;
    if (read_data[WIDTH-1:0] !== 32'h0) begin
      n_fail++; $display("FAIL init_r4_not_forwarded: got %h want 0", read_data[WIDTH-1:0]);
    end
    tick();
    init_req = 1'b0; #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_drop: got %b want 0", ready); end
    for (int k = 0; k < NRD; k++) begin
      n_cmp++;
      if (read_data[k*WIDTH +: WIDTH] !== '0) begin
        n_fail++; $display("FAIL init_clear_read port %0d: got %h want 0", k, read_data[k*WIDTH +: WIDTH]);
      end
    end
    edges = 0;
    while (ready !== 1'b1 && edges < 100) begin
      regwrite = NWR'($urandom); write_reg = NWR*R_WIDTH'($urandom); write_data = {$urandom, $urandom};
      tick();
      edges++;
    end
    regwrite = '0; read_reg = {5'd3, 5'd4}; #1;
    n_cmp++;
    if (edges != REGSIZE) begin n_fail++; $display("FAIL init_sweep_len: got %0d want %0d", edges, REGSIZE); end
    n_cmp++;
    if (read_data !== '0) begin n_fail++; $display("FAIL init_r3_r4: got %h want 0", read_data); end
  endtask

  task automatic test_reset_mid();
    int edges;
    regwrite = 2'b01; write_reg = {5'd0, 5'd2}; write_data = {32'h0, 32'hCAFE};
    tick();
    regwrite = '0; init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0", ready); end
    edges = 0;
    while (ready !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    read_reg = {5'd2, 5'd2}; #1;
    n_cmp++;
    if (edges != REGSIZE) begin n_fail++; $display("FAIL mid_reset_sweep_len: got %0d want %0d", edges, REGSIZE); end
    n_cmp++;
    if (read_data !== '0) begin n_fail++; $display("FAIL mid_reset_r2: got %h want 0", read_data); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] want;
    for (int c = 0; c < 400; c++) begin
      read_reg   = NRD*R_WIDTH'($urandom);
      regwrite   = NWR'($urandom);
      write_reg  = NWR*R_WIDTH'($urandom);
      write_data = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) write_reg[R_WIDTH-1:0] = read_reg[R_WIDTH-1:0];
      init_req   = ($urandom_range(59, 0) == 0);
      #1;
      for (int k = 0; k < NRD; k++) begin
        want = exp_read(int'(read_reg[k*R_WIDTH +: R_WIDTH]));
        n_cmp++;
        if (read_data[k*WIDTH +: WIDTH] !== want) begin
          n_fail++;
          $display("FAIL rand_read cyc %0d port %0d addr %0d: got %h want %h", c, k,
                   read_reg[k*R_WIDTH +: R_WIDTH], read_data[k*WIDTH +: WIDTH], want);
        end
      end
      tick();
      n_cmp++;
      if (ready !== m_ready) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, ready, m_ready);
      end
    end
    init_req = 1'b0; regwrite = '0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr();
    test_bypass();
    test_init_req();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
